// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   - lsu_state_e : FSM states (IDLE, RD, WR, RESP)
//   - SZ_*        : request size codes (2'b11 is folded onto SZ_W at accept)
//   - lsu_req_t   : request fields latched on acceptance
//   - lsu_misaligned() : natural-alignment check for a size/low-address pair
package lsu_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned HALF_W  = 16;
   localparam int unsigned LANE_W  = 2;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_RESP = 2'b11
   } lsu_state_e;

   typedef struct packed {
      logic            we;
      logic [1:0]      size;
      logic            sext;
      logic [XLEN-1:0] wdata;
   } lsu_req_t;

   // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
   function automatic logic lsu_misaligned(input logic [1:0] size,
                                           input logic [LANE_W-1:0] lane);
      logic mis;
      mis = 1'b0;
      if (size == SZ_H)      mis = lane[0];
      else if (size == SZ_W) mis = |lane;
      return mis;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for 32-bit little-endian words.
//   word_i   : word read from memory
//   lane_i   : byte lane (addr[1:0])
//   size_i   : SZ_B / SZ_H / SZ_W (already normalised)
//   sext_i   : sign-extend loaded byte/half
//   wdata_i  : right-aligned store data
//   rdata_o  : extracted and extended load value
//   merged_o : word_i with the store bytes replaced
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0]   word_i,
   input  logic [LANE_W-1:0] lane_i,
   input  logic [1:0]        size_i,
   input  logic              sext_i,
   input  logic [XLEN-1:0]   wdata_i,
   output logic [XLEN-1:0]   rdata_o,
   output logic [XLEN-1:0]   merged_o
);

   logic [BYTE_W-1:0] byte_c;
   logic [HALF_W-1:0] half_c;

   // Extract: pick lane, then extend to full width.
   always_comb begin
      byte_c  = word_i[{lane_i, 3'b000} +: BYTE_W];
      half_c  = lane_i[1] ? word_i[XLEN-1:HALF_W] : word_i[HALF_W-1:0];
      rdata_o = word_i;
      case (size_i)
         SZ_B:    rdata_o = {{(XLEN-BYTE_W){sext_i & byte_c[BYTE_W-1]}}, byte_c};
         SZ_H:    rdata_o = {{(XLEN-HALF_W){sext_i & half_c[HALF_W-1]}}, half_c};
         default: rdata_o = word_i;
      endcase
   end

   // Merge: overwrite only the addressed lanes of the current word.
   always_comb begin
      merged_o = word_i;
      case (size_i)
         SZ_B:    merged_o[{lane_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
         SZ_H:    merged_o[{lane_i[1], 4'b0000} +: HALF_W] = wdata_i[HALF_W-1:0];
         default: merged_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: converts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests
// into word accesses on a single-port memory with combinational read data.
// Sub-word stores are read-modify-write (RD then WR).
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word requests complete at once with resp_err=1
//   undefined : low address bits are forced to natural alignment, resp_err=0
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_we/size/sext/addr/wdata      request payload
//   resp_valid/resp_rdata/resp_err   one-cycle completion pulse and result
//   mem_we/mem_addr/mem_wd/mem_rd    word memory port
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_sext,
   input  logic [31:0]      req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic             mem_we,
   output logic [DEPTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wd,
   input  logic [WIDTH-1:0] mem_rd
);

   localparam int unsigned AW = DEPTH + 2;

   lsu_state_e      state_q, state_d;
   lsu_req_t        req_q, req_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [XLEN-1:0] word_q, word_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            err_q, err_d;
   logic            ready_q, ready_d;
   logic            valid_q, valid_d;
   logic            we_q, we_d;

   logic [1:0]      size_n_c;
   logic [AW-1:0]   addr_n_c;
   logic            misalign_c;
   logic [XLEN-1:0] ext_rdata_c;
   logic [XLEN-1:0] merged_c;
   logic            unused_addr_hi;

   // Upper address bits alias onto the memory; they are intentionally dropped.
   assign unused_addr_hi = ^req_addr[31:AW];

   // Normalise the incoming request: size 11 acts as word, alignment policy.
   always_comb begin
      size_n_c = (req_size == 2'b11) ? SZ_W : req_size;
      addr_n_c = req_addr[AW-1:0];
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_c = lsu_misaligned(size_n_c, req_addr[LANE_W-1:0]);
`else
      misalign_c = 1'b0;
      if (size_n_c == SZ_H)      addr_n_c[0]   = 1'b0;
      else if (size_n_c == SZ_W) addr_n_c[1:0] = 2'b00;
`endif
   end

   lsu_lane_align u_align (
      .word_i   (XLEN'(mem_rd)),
      .lane_i   (addr_q[LANE_W-1:0]),
      .size_i   (req_q.size),
      .sext_i   (req_q.sext),
      .wdata_i  (req_q.wdata),
      .rdata_o  (ext_rdata_c),
      .merged_o (merged_c)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      word_d  = word_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               req_d.we    = req_we;
               req_d.size  = size_n_c;
               req_d.sext  = req_sext;
               req_d.wdata = XLEN'(req_wdata);
               addr_d      = addr_n_c;
               if (misalign_c) begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else if (req_we && (size_n_c == SZ_W)) begin
                  word_d  = XLEN'(req_wdata);
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (req_q.we) begin
               word_d  = merged_c;
               state_d = ST_WR;
            end else begin
               rdata_d = ext_rdata_c;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end
         end
         ST_WR: begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_IDLE);
      valid_d = (state_d == ST_RESP);
      we_d    = (state_d == ST_WR);
   end

   // State and latch registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         addr_q  <= '0;
         word_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         we_q    <= we_d;
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = valid_q;
   assign resp_rdata = WIDTH'(rdata_q);
   assign resp_err   = err_q;
   // Gate with reset_n so a reset landing in WR never commits the write.
   assign mem_we     = we_q & reset_n;
   assign mem_addr   = addr_q[AW-1:LANE_W];
   assign mem_wd     = WIDTH'(word_q);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of directed requests with expected
// result/error/latency/write count, plus reset sequences.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_we, req_sext;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wd, mem_rd;

   logic [31:0] mem [0:255];
   int          wr_cnt = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_wr;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   load_store_unit #(.WIDTH(32), .DEPTH(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_sext   (req_sext),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   assign mem_rd = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wd;
         wr_cnt        <= wr_cnt + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic we, input logic [1:0] size, input logic sext,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] er, input logic ee, input int el, input int ew);
      vec_t v;
      v.name = nm; v.we = we; v.size = size; v.sext = sext; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_wr = ew;
      vecs.push_back(v);
   endtask

   // Issue one request, measure latency from the accept edge, check result.
   task automatic run_req(input vec_t v);
      int   lat;
      int   wr0;
      logic got;
      lat = 0;
      while (!req_ready && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk({v.name, " ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_sext = v.sext;
      req_addr = v.addr; req_wdata = v.wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wr0 = wr_cnt;
      got = 1'b0;
      lat = 0;
      while (!got && lat < 8) begin
         @(negedge clk);
         lat++;
         if (lat == 1) chk({v.name, " busy"}, 32'(req_ready), 32'd0);
         if (resp_valid) got = 1'b1;
      end
      chk({v.name, " resp_seen"}, 32'(got), 32'd1);
      chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
      chk({v.name, " rdata"}, resp_rdata, v.exp_rdata);
      chk({v.name, " err"}, 32'(resp_err), 32'(v.exp_err));
      chk({v.name, " writes"}, 32'(wr_cnt - wr0), 32'(v.exp_wr));
      @(negedge clk);
      chk({v.name, " pulse"}, 32'(resp_valid), 32'd0);
   endtask

`ifdef LSU_MISALIGN_TRAP_EN
   localparam logic [31:0] W4_FINAL = 32'h11AA3344;
`else
   localparam logic [31:0] W4_FINAL = 32'hBEEF3344;
`endif

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;

      // Reset with a request held: nothing accepted, nothing written.
      reset_n = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_sext = 1'b0;
      req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
      repeat (3) @(negedge clk);
      chk("rst req_ready", 32'(req_ready), 32'd1);
      chk("rst resp_valid", 32'(resp_valid), 32'd0);
      chk("rst resp_rdata", resp_rdata, 32'd0);
      chk("rst resp_err", 32'(resp_err), 32'd0);
      chk("rst mem_we", 32'(mem_we), 32'd0);
      chk("rst mem_addr", 32'(mem_addr), 32'd0);
      chk("rst mem_wd", mem_wd, 32'd0);
      chk("rst writes", 32'(wr_cnt), 32'd0);
      req_valid = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      chk("post-rst req_ready", 32'(req_ready), 32'd1);

      //  name         we  size  sext addr          wdata          exp_rdata     err lat wr
      add("sw_dead",   1, 2'b10, 0, 32'h10,       32'hDEADBEEF,  32'h0,        0, 2, 1);
      add("lw_dead",   0, 2'b10, 0, 32'h10,       32'h0,         32'hDEADBEEF, 0, 2, 0);
      add("sw_1122",   1, 2'b10, 0, 32'h10,       32'h11223344,  32'h0,        0, 2, 1);
      add("sb_aa",     1, 2'b00, 0, 32'h12,       32'h123456AA,  32'h0,        0, 3, 1);
      add("lw_merged", 0, 2'b10, 0, 32'h10,       32'h0,         32'h11AA3344, 0, 2, 0);
      add("lb_aa",     0, 2'b00, 1, 32'h12,       32'h0,         32'hFFFFFFAA, 0, 2, 0);
      add("lbu_aa",    0, 2'b00, 0, 32'h12,       32'h0,         32'h000000AA, 0, 2, 0);
      add("lb_lane3",  0, 2'b00, 1, 32'h13,       32'h0,         32'h00000011, 0, 2, 0);
      add("sh_8001",   1, 2'b01, 0, 32'h16,       32'hFFFF8001,  32'h0,        0, 3, 1);
      add("lw_w5",     0, 2'b10, 0, 32'h14,       32'h0,         32'h80010000, 0, 2, 0);
      add("lh_8001",   0, 2'b01, 1, 32'h16,       32'h0,         32'hFFFF8001, 0, 2, 0);
      add("lhu_8001",  0, 2'b01, 0, 32'h16,       32'h0,         32'h00008001, 0, 2, 0);
      add("lh_lo",     0, 2'b01, 1, 32'h14,       32'h0,         32'h00000000, 0, 2, 0);
      add("lw_sz11",   0, 2'b11, 0, 32'h10,       32'h0,         32'h11AA3344, 0, 2, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      add("lw_mis",    0, 2'b10, 0, 32'h11,       32'h0,         32'h0,        1, 1, 0);
      add("sh_mis",    1, 2'b01, 0, 32'h13,       32'h0000BEEF,  32'h0,        1, 1, 0);
`else
      add("lw_mis",    0, 2'b10, 0, 32'h11,       32'h0,         32'h11AA3344, 0, 2, 0);
      add("sh_mis",    1, 2'b01, 0, 32'h13,       32'h0000BEEF,  32'h0,        0, 3, 1);
`endif
      add("lw_after",  0, 2'b10, 0, 32'h10,       32'h0,         W4_FINAL,     0, 2, 0);
      add("lb_w8",     0, 2'b00, 1, 32'h21,       32'h0,         32'h0,        0, 2, 0);
      add("lw_alias",  0, 2'b10, 0, 32'h410,      32'h0,         W4_FINAL,     0, 2, 0);

      foreach (vecs[i]) run_req(vecs[i]);

      // Reset while a sub-word store is in WR: write dropped, no response.
      begin
         int w0;
         int seen;
         w0 = wr_cnt;
         req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_sext = 1'b0;
         req_addr = 32'h10; req_wdata = 32'h00000055;
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         @(negedge clk);
         @(negedge clk);
         chk("rstwr in_wr", 32'(mem_we), 32'd1);
         reset_n = 1'b0;
         #1;
         chk("rstwr gated", 32'(mem_we), 32'd0);
         @(negedge clk);
         chk("rstwr ready", 32'(req_ready), 32'd1);
         chk("rstwr mem_we", 32'(mem_we), 32'd0);
         reset_n = 1'b1;
         seen = 0;
         repeat (4) begin
            @(negedge clk);
            if (resp_valid) seen++;
         end
         chk("rstwr no_resp", 32'(seen), 32'd0);
         chk("rstwr no_write", 32'(wr_cnt - w0), 32'd0);
         chk("rstwr word4", mem[4], W4_FINAL);
         chk("rstwr idle", 32'(req_ready), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
